lowentropy_prefix_accum: RTL
============================

# lowentropy_prefix_accum

Sequential active-prefix accumulator for the hybrid entropy coder's low-entropy path. It keeps one independent active prefix per code table and appends each incoming 4-bit input symbol to the prefix of the table it addresses. After each append it queries an external combinational codebook bus with the candidate prefix. On a match it emits the codeword through a valid/ready port and clears that prefix. On a flush request it walks every non-empty prefix through the flush codebooks, then signals completion.

## Interface
- NUM_TABLES, 16, number of low-entropy code tables / active prefixes
- CODEBOOK_LENGTH_MAX, 64, prefix register width in bits (4 bits per symbol)
- ENCODE_DATALENGTH, 21, codeword width
- Derived localparams: TABLE_W = $clog2(NUM_TABLES); MAX_DIGITS = CODEBOOK_LENGTH_MAX/4
- Single clock domain. Reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- sym_valid_i  in  1  input symbol valid
- sym_ready_o  out  1  input symbol ready
- sym_table_i  in  TABLE_W  target table index
- sym_data_i  in  4  input symbol, 'hF = escape
- flush_i  in  1  flush request pulse
- lk_table_o  out  TABLE_W  lookup table index
- lk_flush_o  out  1  lookup selects flush codebook
- lk_cnt_o  out  6  candidate prefix length in symbols
- lk_data_o  out  CODEBOOK_LENGTH_MAX  candidate prefix, newest symbol in bits [3:0]
- lk_match_i  in  1  codebook match
- lk_length_i  in  6  matched codeword length
- lk_data_i  in  ENCODE_DATALENGTH  matched codeword, right-aligned
- cw_valid_o  out  1  codeword valid
- cw_ready_i  in  1  codeword ready
- cw_length_o  out  6  codeword length
- cw_data_o  out  ENCODE_DATALENGTH  codeword
- cw_table_o  out  TABLE_W  source table
- err_overflow_o  out  1  sticky: prefix reached MAX_DIGITS with no match
- err_flush_o  out  1  sticky: flush lookup returned no match
- flush_done_o  out  1  one-cycle pulse at flush completion

## Operation
- State per table: prefix[CODEBOOK_LENGTH_MAX] and cnt[6], both 0 at reset.
- FSM states: IDLE, LOOKUP, EMIT, F_SCAN, F_LOOKUP, F_EMIT.
- sym_ready_o = (state==IDLE) && !flush_pend && !flush_i.
- A symbol is accepted when sym_valid_i && sym_ready_o.
- Accept captures the candidate (prefix[t]<<4)|sym with cnt[t]+1 into a candidate register, then moves to LOOKUP.
- The upper bits shifted out of the prefix are discarded.
- LOOKUP: the candidate drives lk_*, with lk_flush_o=0. lk_match_i is sampled this cycle.
  - Match: latch cw regs, clear prefix[t] and cnt[t], go to EMIT.
  - No match, candidate cnt < MAX_DIGITS: write the candidate back to prefix[t]/cnt[t], go to IDLE.
  - No match, candidate cnt == MAX_DIGITS: set err_overflow_o, clear prefix[t]/cnt[t], go to IDLE.
- EMIT: cw_valid_o=1 and all cw_* held stable until cw_ready_i. Then go to IDLE.
- Flush request:
  - flush_i sets flush_pend in any state.
  - Flush starts from IDLE when flush_pend is set: idx=0, go to F_SCAN.
  - Same-cycle flush_i and sym_valid_i in IDLE: flush wins and the symbol is not accepted.
- F_SCAN:
  - cnt[idx]==0: advance idx.
  - Otherwise go to F_LOOKUP.
  - After idx==NUM_TABLES-1 completes: pulse flush_done_o, clear flush_pend, go to IDLE.
- F_LOOKUP: lk_flush_o=1, driving prefix[idx]/cnt[idx].
  - Match: latch cw, go to F_EMIT.
  - No match: set err_flush_o.
  - In both cases clear prefix[idx]/cnt[idx].
  - On no match, advance idx and return to F_SCAN.
- F_EMIT: same handshake as EMIT, then advance idx and return to F_SCAN.
- Outside LOOKUP/F_LOOKUP, lk_* are driven to 0.
- Error flags are sticky and cleared only by reset.

## Timing
- Reset values:
  - sym_ready_o=1 after reset release.
  - All other outputs 0; state IDLE; all prefixes empty; flush_pend=0.
- Non-matching symbol: accepted in cycle N, LOOKUP in N+1, sym_ready_o high again in N+2. Throughput is 1 symbol per 2 cycles.
- Matching symbol: accepted in cycle N, cw_valid_o high from N+2. With cw_ready_i=1, the next accept is possible in N+3.
- Flush cycle counts:
  - 1 cycle per empty table.
  - 1 cycle per F_SCAN/F_LOOKUP step for each non-empty table, plus the F_EMIT hold time.
  - flush_done_o fires in the cycle after the last table is processed.
- Reset asserted mid-operation: any codeword in flight is dropped and all state clears immediately. No partial output is allowed.

## Test plan
All tests use a bench lookup model for table 4: F→(8,'b11100100); 0F→(9,'b111101110); 00F→(10,'b1111101011). Flush model for table 4: 0→(5,'b10101).
- Reset: hold rst_n_i low, then release → all outputs 0 and sym_ready_o=1 within the first cycle.
- Table 4 symbols 0,0,F:
  - First two lookups: lk_cnt_o=1 then 2, no match.
  - Third lookup: lk_cnt_o=3, lk_data_o='h00F.
  - Result: cw_valid_o with cw_length_o=10, cw_data_o='b1111101011, cw_table_o=4.
- Table 4 symbol F with cw_ready_i low for 5 cycles → cw_valid_o and cw_* stable throughout, sym_ready_o=0, a single transfer on release.
- Interleave table 2 sym 3, table 4 sym 0, table 4 sym F → table 4 emits the 9-bit codeword and table 2 keeps prefix 'h3 with cnt 1.
- Load table 4 with sym 0, then pulse flush_i together with sym_valid_i:
  - The symbol is not accepted.
  - The flush lookup shows lk_flush_o=1, table 4, cnt 1, data 'h0.
  - Result: cw (5,'b10101), then a flush_done_o pulse.
- Bench model set to never match; feed 16 symbols to table 0 → err_overflow_o rises after the 16th LOOKUP and the table 0 prefix is empty.

Source files
------------

// File: rtl/lowentropy_prefix_accum.sv
// lowentropy_prefix_accum
//   Keeps one active symbol prefix per low-entropy code table. Each accepted
//   4-bit symbol is appended to its table's prefix and the candidate is shown
//   to an external combinational codebook. A match emits the codeword on a
//   valid/ready port and empties the prefix. A flush walks every non-empty
//   prefix through the flush codebooks and then pulses flush_done_o.
//
// Ports
//   clk_i, rst_n_i                  clock, async active-low reset
//   sym_valid_i/sym_ready_o         input symbol handshake
//   sym_table_i, sym_data_i         target table, 4-bit symbol
//   flush_i                         flush request pulse
//   lk_table_o/lk_flush_o/lk_cnt_o/lk_data_o   codebook query
//   lk_match_i/lk_length_i/lk_data_i           codebook answer (same cycle)
//   cw_valid_o/cw_ready_i           codeword handshake
//   cw_length_o/cw_data_o/cw_table_o           codeword payload
//   err_overflow_o, err_flush_o     sticky error flags
//   flush_done_o                    one-cycle flush completion pulse
//
// States
//   IDLE     | waiting for a symbol or a pending flush
//   LOOKUP   | candidate prefix on the codebook bus
//   EMIT     | codeword held until cw_ready_i
//   F_SCAN   | flush: skip empty table idx, else go query it
//   F_LOOKUP | flush: prefix[idx] on the flush codebook bus
//   F_EMIT   | flush: codeword held until cw_ready_i
module lowentropy_prefix_accum #(
  parameter int NUM_TABLES          = 16,
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21,
  localparam int TABLE_W            = $clog2(NUM_TABLES),
  localparam int MAX_DIGITS         = CODEBOOK_LENGTH_MAX / 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           sym_valid_i,
  output logic                           sym_ready_o,
  input  logic [TABLE_W-1:0]             sym_table_i,
  input  logic [3:0]                     sym_data_i,
  input  logic                           flush_i,
  output logic [TABLE_W-1:0]             lk_table_o,
  output logic                           lk_flush_o,
  output logic [5:0]                     lk_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] lk_data_o,
  input  logic                           lk_match_i,
  input  logic [5:0]                     lk_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   lk_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [5:0]                     cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic [TABLE_W-1:0]             cw_table_o,
  output logic                           err_overflow_o,
  output logic                           err_flush_o,
  output logic                           flush_done_o
);

  localparam logic [5:0]         MAX_CNT  = 6'(MAX_DIGITS);
  localparam logic [TABLE_W-1:0] LAST_IDX = TABLE_W'(NUM_TABLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EMIT,
    F_SCAN,
    F_LOOKUP,
    F_EMIT
  } state_t;

  state_t state_q, state_d;

  logic [CODEBOOK_LENGTH_MAX-1:0] prefix_q [NUM_TABLES];
  logic [5:0]                     cnt_q    [NUM_TABLES];

  logic [CODEBOOK_LENGTH_MAX-1:0] cand_data_q;
  logic [5:0]                     cand_cnt_q;
  logic [TABLE_W-1:0]             cand_table_q;
  logic [TABLE_W-1:0]             idx_q;
  logic                           flush_pend_q;
  logic [5:0]                     cw_length_q;
  logic [ENCODE_DATALENGTH-1:0]   cw_data_q;
  logic [TABLE_W-1:0]             cw_table_q;
  logic                           err_overflow_q;
  logic                           err_flush_q;
  logic                           flush_done_q;

  logic sym_accept;
  logic flush_finish;
  logic idx_last;
  logic idx_empty;

  // A flush request in the same cycle blocks the symbol.
  assign sym_ready_o = (state_q == IDLE) && !flush_pend_q && !flush_i;
  assign sym_accept  = sym_valid_i && sym_ready_o;
  assign idx_last    = (idx_q == LAST_IDX);
  assign idx_empty   = (cnt_q[idx_q] == 6'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lk_table_o   = '0;
    lk_flush_o   = 1'b0;
    lk_cnt_o     = '0;
    lk_data_o    = '0;
    cw_valid_o   = 1'b0;
    flush_finish = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d = F_SCAN;
        end else if (sym_accept) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        lk_table_o = cand_table_q;
        lk_cnt_o   = cand_cnt_q;
        lk_data_o  = cand_data_q;
        state_d    = lk_match_i ? EMIT : IDLE;
      end
      EMIT: begin
        cw_valid_o = 1'b1;
        if (cw_ready_i) begin
          state_d = IDLE;
        end
      end
      F_SCAN: begin
        if (!idx_empty) begin
          state_d = F_LOOKUP;
        end else if (idx_last) begin
          state_d      = IDLE;
          flush_finish = 1'b1;
        end
      end
      F_LOOKUP: begin
        lk_table_o = idx_q;
        lk_flush_o = 1'b1;
        lk_cnt_o   = cnt_q[idx_q];
        lk_data_o  = prefix_q[idx_q];
        if (lk_match_i) begin
          state_d = F_EMIT;
        end else if (idx_last) begin
          state_d      = IDLE;
          flush_finish = 1'b1;
        end else begin
          state_d = F_SCAN;
        end
      end
      F_EMIT: begin
        cw_valid_o = 1'b1;
        if (cw_ready_i) begin
          if (idx_last) begin
            state_d      = IDLE;
            flush_finish = 1'b1;
          end else begin
            state_d = F_SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_TABLES; i++) begin
        prefix_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      cand_data_q    <= '0;
      cand_cnt_q     <= '0;
      cand_table_q   <= '0;
      idx_q          <= '0;
      flush_pend_q   <= 1'b0;
      cw_length_q    <= '0;
      cw_data_q      <= '0;
      cw_table_q     <= '0;
      err_overflow_q <= 1'b0;
      err_flush_q    <= 1'b0;
      flush_done_q   <= 1'b0;
    end else begin
      flush_done_q <= flush_finish;
      // A new request arriving as a flush completes must not be lost.
      if (flush_i) begin
        flush_pend_q <= 1'b1;
      end else if (flush_finish) begin
        flush_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (flush_pend_q) begin
            idx_q <= '0;
          end else if (sym_accept) begin
            cand_data_q  <= {prefix_q[sym_table_i][CODEBOOK_LENGTH_MAX-5:0], sym_data_i};
            cand_cnt_q   <= cnt_q[sym_table_i] + 6'd1;
            cand_table_q <= sym_table_i;
          end
        end
        LOOKUP: begin
          if (lk_match_i) begin
            cw_length_q            <= lk_length_i;
            cw_data_q              <= lk_data_i;
            cw_table_q             <= cand_table_q;
            prefix_q[cand_table_q] <= '0;
            cnt_q[cand_table_q]    <= '0;
          end else if (cand_cnt_q == MAX_CNT) begin
            err_overflow_q         <= 1'b1;
            prefix_q[cand_table_q] <= '0;
            cnt_q[cand_table_q]    <= '0;
          end else begin
            prefix_q[cand_table_q] <= cand_data_q;
            cnt_q[cand_table_q]    <= cand_cnt_q;
          end
        end
        F_SCAN: begin
          if (idx_empty) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        F_LOOKUP: begin
          prefix_q[idx_q] <= '0;
          cnt_q[idx_q]    <= '0;
          if (lk_match_i) begin
            cw_length_q <= lk_length_i;
            cw_data_q   <= lk_data_i;
            cw_table_q  <= idx_q;
          end else begin
            err_flush_q <= 1'b1;
            idx_q       <= idx_q + 1'b1;
          end
        end
        F_EMIT: begin
          if (cw_ready_i) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload is only visible while a codeword is being offered.
  assign cw_length_o    = cw_valid_o ? cw_length_q : '0;
  assign cw_data_o      = cw_valid_o ? cw_data_q : '0;
  assign cw_table_o     = cw_valid_o ? cw_table_q : '0;
  assign err_overflow_o = err_overflow_q;
  assign err_flush_o    = err_flush_q;
  assign flush_done_o   = flush_done_q;

endmodule
